// File: rtl/byte_joining_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// byte_joining_ctrl_pkg
//   Shared definitions for the byte-joining sequencer: lane_mode encodings,
//   FSM state codes and the helper that turns a lane_mode into a lane count.
// ----------------------------------------------------------------------------
package byte_joining_ctrl_pkg;

    localparam int NUM_LANES = 4;
    localparam int CTR_W     = 2;

    typedef enum logic [1:0] {
        LM_X1   = 2'b00,
        LM_X2   = 2'b01,
        LM_X4   = 2'b10,
        LM_RSVD = 2'b11
    } lane_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    // Number of active lanes for a lane_mode. The reserved code behaves as x4
    // so a misconfigured link still delivers every captured byte.
    function automatic logic [2:0] lanes_from_mode(input logic [1:0] mode);
        logic [2:0] lanes;
        case (lane_mode_e'(mode))
            LM_X1:   lanes = 3'd1;
            LM_X2:   lanes = 3'd2;
            default: lanes = 3'd4;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/byte_joining_ctrl_hold.sv
// ----------------------------------------------------------------------------
// byte_joining_hold
//   Holds one captured 4-lane word and presents the lane picked by i_sel.
//   Ports:
//     i_clk      clock, all registers on posedge
//     i_srst     synchronous active-high reset, clears the held word
//     i_capture  load i_lanes into the holding registers
//     i_lanes    four lane bytes, index 0 = Lane_0
//     i_sel      lane index to present on o_byte
//     o_byte     held lane[i_sel]
// ----------------------------------------------------------------------------
module byte_joining_hold
    import byte_joining_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                                i_clk,
    input  logic                                i_srst,
    input  logic                                i_capture,
    input  logic [NUM_LANES-1:0][DATA_W-1:0]    i_lanes,
    input  logic [CTR_W-1:0]                    i_sel,
    output logic [DATA_W-1:0]                   o_byte
);

    logic [DATA_W-1:0] w_lane [NUM_LANES];

    // All lanes are captured regardless of the active width; unused lanes are
    // simply never selected.
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        logic [DATA_W-1:0] r_lane;

        always_ff @(posedge i_clk) begin
            if (i_srst) begin
                r_lane <= '0;
            end else if (i_capture) begin
                r_lane <= i_lanes[gi];
            end
        end

        assign w_lane[gi] = r_lane;
    end

    assign o_byte = w_lane[i_sel];

endmodule

// File: rtl/byte_joining_ctrl.sv
// ----------------------------------------------------------------------------
// byte_joining_ctrl
//   Flow-controlled sequencer that turns one 4-lane word per in_valid/in_ready
//   handshake into a byte stream (Lane_0 first) on out_valid/out_ready.
//   Supports x1/x2/x4 lane widths; the width is latched with each word.
//   Ports:
//     clk1Mhz     clock, all logic on posedge
//     reset       synchronous active-high reset, drops any word in flight
//     lane_mode   00=x1, 01=x2, 10=x4, 11=reserved (runs as x4, flags mode_err)
//     in_valid    Lane_0..Lane_3 hold a word
//     in_ready    a word is taken this cycle (combinational from out_ready)
//     Lane_0..3   lane bytes
//     out_ready   consumer takes out_byte this cycle
//     out_valid   out_byte is valid
//     out_byte    held lane[ctr_3]
//     ctr_3       index of the lane being output
//     word_first  out_byte is lane 0 of a word
//     word_last   out_byte is the last active lane of a word
//     mode_err    sticky: a word was taken with lane_mode=11
// ----------------------------------------------------------------------------
module byte_joining_ctrl
    import byte_joining_ctrl_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk1Mhz,
    input  logic                reset,
    input  logic [1:0]          lane_mode,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   Lane_0,
    input  logic [DATA_W-1:0]   Lane_1,
    input  logic [DATA_W-1:0]   Lane_2,
    input  logic [DATA_W-1:0]   Lane_3,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_byte,
    output logic [1:0]          ctr_3,
    output logic                word_first,
    output logic                word_last,
    output logic                mode_err
);

    state_e                             r_state;
    state_e                             w_state_next;
    logic [CTR_W-1:0]                   r_ctr;
    logic [CTR_W-1:0]                   w_ctr_next;
    logic [CTR_W-1:0]                   r_last_idx;
    logic [CTR_W-1:0]                   w_last_idx_next;
    logic                               r_mode_err;
    logic                               w_mode_err_next;
    logic                               w_capture;
    logic                               w_in_ready;
    logic                               w_is_last;
    logic [CTR_W-1:0]                   w_cap_last_idx;
    logic [NUM_LANES-1:0][DATA_W-1:0]   w_lanes;

    assign w_lanes        = {Lane_3, Lane_2, Lane_1, Lane_0};
    // Storing N-1 rather than N keeps the last-lane compare at counter width.
    assign w_cap_last_idx = CTR_W'(lanes_from_mode(lane_mode) - 3'd1);
    assign w_is_last      = (r_ctr == r_last_idx);

    always_ff @(posedge clk1Mhz) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_ctr      <= '0;
            r_last_idx <= '0;
            r_mode_err <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ctr      <= w_ctr_next;
            r_last_idx <= w_last_idx_next;
            r_mode_err <= w_mode_err_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_ctr_next      = r_ctr;
        w_last_idx_next = r_last_idx;
        w_mode_err_next = r_mode_err;
        w_in_ready      = 1'b0;
        w_capture       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_in_ready = 1'b1;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (w_is_last) begin
                        // Last byte leaves now, so the holding registers are
                        // free this very cycle: accept the next word without
                        // a bubble, otherwise fall back to IDLE.
                        w_in_ready   = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
                        w_ctr_next = r_ctr + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (w_in_ready && in_valid) begin
            w_capture       = 1'b1;
            w_state_next    = ST_SEND;
            w_ctr_next      = '0;
            w_last_idx_next = w_cap_last_idx;
            if (lane_mode == LM_RSVD) begin
                w_mode_err_next = 1'b1;
            end
        end
    end

    byte_joining_hold #(
        .DATA_W     (DATA_W)
    ) u_hold (
        .i_clk      (clk1Mhz),
        .i_srst     (reset),
        .i_capture  (w_capture),
        .i_lanes    (w_lanes),
        .i_sel      (r_ctr),
        .o_byte     (out_byte)
    );

    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state == ST_SEND);
    assign word_first = (r_state == ST_SEND) && (r_ctr == '0);
    assign word_last  = (r_state == ST_SEND) && w_is_last;
    assign ctr_3      = r_ctr;
    assign mode_err   = r_mode_err;

endmodule
